// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default byte
// width and a width helper for index and counter sizing.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: rotates the request vector so the source
// after last_i sits at bit 0, then takes the lowest set bit.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      last_i,
  output logic [GW-1:0]      winner_o,
  output logic               found_o
);

  logic [NUM_REQ-1:0] rot;
  int                 base;
  int                 off;

  always_comb begin
    base    = (int'(last_i) + 1) % NUM_REQ;
    rot     = '0;
    off     = 0;
    found_o = |req_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = req_i[(base + k) % NUM_REQ];
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    winner_o = GW'((base + off) % NUM_REQ);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with a start-acknowledge timeout and per-source capture/completion pulses.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int START_TO = 1024,
  localparam int GW       = clog2(NUM_REQ),
  localparam int CW       = (clog2(START_TO) < 1) ? 1 : clog2(START_TO)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [GW-1:0]             grant_id,
  output logic                      active,
  output logic                      err_timeout
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic                active_q, active_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [GW-1:0]       winner;
  logic                found;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req_i    (req_valid),
    .last_i   (last_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // NOTE: every _d gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = tx_start_q;
    req_ready_d = '0;
    req_done_d  = '0;
    grant_d     = grant_q;
    last_d      = last_q;
    active_d    = active_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    // A done pulse completes the transfer even if busy was never observed.
    if (state_q != IDLE && tx_done) begin
      req_done_d[grant_q] = 1'b1;
      last_d              = grant_q;
      active_d            = 1'b0;
      tx_start_d          = 1'b0;
      state_d             = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en && found) begin
            tx_data_d           = req_data[winner*DATA_W +: DATA_W];
            grant_d             = winner;
            req_ready_d[winner] = 1'b1;
            tx_start_d          = 1'b1;
            active_d            = 1'b1;
            cnt_d               = '0;
            state_d             = START;
          end
        end
        START: begin
          if (tx_busy) begin
            tx_start_d = 1'b0;
            state_d    = WAIT_DONE;
          end else if (cnt_q == CW'(START_TO - 1)) begin
            tx_start_d = 1'b0;
            err_d      = 1'b1;
            active_d   = 1'b0;
            last_d     = grant_q;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      req_done_q  <= '0;
      grant_q     <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      active_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      req_done_q  <= req_done_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      active_q    <= active_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign req_ready   = req_ready_q;
  assign req_done    = req_done_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a behavioural transmitter, per-source
// byte queues and a grant/completion scoreboard checked with immediate asserts.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic            en;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_done;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            active;
  logic            err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ  (NR),
    .DATA_W   (DW),
    .START_TO (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [7:0] data;
    bit         to;
  } exp_t;

  exp_t       gq[$];
  exp_t       dq[$];
  logic [7:0] src_q[NR][$];

  int n_assert = 0;
  int n_fail   = 0;
  bit xmit_dead = 1'b0;
  int xm_phase  = 0;
  int xm_cnt    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requesters: present the next queued byte, or drop valid, after a capture.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (rst && req_ready[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) req_data[i*DW +: DW] = src_q[i][0];
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic post(input int src, input logic [7:0] b, input bit to);
    exp_t e;
    e.src = src; e.data = b; e.to = to;
    gq.push_back(e);
    src_q[src].push_back(b);
    if (!req_valid[src]) begin
      req_valid[src]        = 1'b1;
      req_data[src*DW +: DW] = b;
    end
  endtask

  function automatic bit quiet();
    return gq.size() == 0 && dq.size() == 0 && active == 1'b0 && req_valid == '0
           && xm_phase == 0 && !tx_busy && !tx_done;
  endfunction

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while (!quiet() && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(quiet()), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_busy), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_req_done"}, 32'(req_done), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  // Transmitter model: busy one cycle after start is seen, frame lasts four
  // cycles, then a one-cycle done pulse.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      case (xm_phase)
        0: if (tx_start === 1'b1 && !xmit_dead) xm_phase = 1;
        1: begin
          tx_busy  = 1'b1;
          xm_cnt   = 0;
          xm_phase = 2;
        end
        default: begin
          xm_cnt++;
          if (xm_cnt == 4) begin
            tx_busy  = 1'b0;
            tx_done  = 1'b1;
            xm_phase = 0;
          end
        end
      endcase
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && req_ready !== '0) begin
        if (gq.size() == 0) check("unexpected_grant", 32'(req_ready), 32'd0);
        else begin
          e  = gq.pop_front();
          oh = 4'b0001 << e.src;
          check("req_ready", 32'(req_ready), 32'(oh));
          check("grant_id", 32'(grant_id), 32'(e.src));
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("tx_start_at_grant", 32'(tx_start), 32'd1);
          check("active_at_grant", 32'(active), 32'd1);
          dq.push_back(e);
        end
      end
      if (rst === 1'b1 && req_done !== '0) begin
        if (dq.size() == 0) check("unexpected_done", 32'(req_done), 32'd0);
        else begin
          e  = dq.pop_front();
          oh = 4'b0001 << e.src;
          check("done_not_timeout", 32'(e.to), 32'd0);
          check("req_done", 32'(req_done), 32'(oh));
          check("active_at_done", 32'(active), 32'd0);
        end
      end
      if (rst === 1'b1 && err_timeout === 1'b1) begin
        if (dq.size() == 0) check("unexpected_timeout", 32'(err_timeout), 32'd0);
        else begin
          e = dq.pop_front();
          check("timeout_expected", 32'(e.to), 32'd1);
          check("no_done_on_timeout", 32'(req_done), 32'd0);
          check("active_at_timeout", 32'(active), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int starts;
    rst       = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    req_data  = '0;

    // Reset values.
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    en  = 1'b1;
    tick();

    // Single source.
    post(0, 8'h41, 1'b0);
    wait_quiet("single_src0", 60);

    // en gating, then en dropped during WAIT_DONE.
    en = 1'b0;
    post(2, 8'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en0_no_ready", 32'(req_ready), 32'd0);
      check("en0_no_start", 32'(tx_start), 32'd0);
    end
    en = 1'b1;
    wait_busy("en_busy_seen");
    tick();
    en = 1'b0;
    wait_quiet("en_drop_wait_done", 60);
    en = 1'b1;

    // Single src3 leaves last_grant at 3.
    post(3, 8'h33, 1'b0);
    wait_quiet("single_src3", 60);

    // Simultaneous requests with back-to-back gap.
    post(0, 8'h41, 1'b0);
    post(1, 8'h42, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (req_done !== 4'b0001 && n < 60);
    check("b2b_first_done", 32'(req_done), 32'h1);
    tick();
    check("b2b_one_idle_gap", 32'(req_ready), 32'h2);
    wait_quiet("simultaneous", 60);

    // Start timeout on src2, then src3 is served normally.
    xmit_dead = 1'b1;
    post(2, 8'h99, 1'b1);
    post(3, 8'h9a, 1'b0);
    n      = 0;
    starts = 0;
    do begin
      tick();
      n++;
      if (tx_start === 1'b1) starts++;
    end while (err_timeout !== 1'b1 && n < 100);
    check("timeout_seen", 32'(err_timeout), 32'd1);
    check("start_hold_cycles", 32'(starts), 32'(TO));
    xmit_dead = 1'b0;
    wait_quiet("after_timeout", 60);

    // Complete src1, then reset while src2 is in WAIT_DONE.
    post(1, 8'h71, 1'b0);
    wait_quiet("single_src1", 60);
    post(2, 8'h72, 1'b0);
    wait_busy("rst_busy_seen");
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("mid_reset");
    dq.delete();
    n = 0;
    while (!(xm_phase == 0 && !tx_busy && !tx_done) && n < 30) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();

    // Fairness: all four sources, two bytes each; src0 must win first.
    for (int i = 0; i < NR; i++) post(i, 8'ha0 + 8'(i), 1'b0);
    for (int i = 0; i < NR; i++) post(i, 8'hb0 + 8'(i), 1'b0);
    wait_quiet("fairness", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_transmitter among NUM_REQ independent byte sources. Each source posts a byte with a valid/ready handshake. The block picks one source round-robin, latches its byte, and drives tx_data/tx_start into the transmitter. It then watches tx_busy/tx_done and signals completion back to the winning source. It sits between the requester logic and uart_transmitter, on the same clk and baud domain.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, byte width; matches the transmitter tx_data width
START_TO, 1024, max clk cycles to wait for tx_busy after asserting tx_start

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
en  input  1  1 = new grants allowed; 0 = finish the current transfer, then hold in IDLE
req_valid  input  NUM_REQ  per-source byte pending
req_data  input  NUM_REQ*DATA_W  packed bytes; source i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot, one-cycle pulse: byte of source i captured
req_done  output  NUM_REQ  one-hot, one-cycle pulse: byte of source i fully serialised
tx_data  output  DATA_W  byte to the transmitter; held stable for the whole transfer
tx_start  output  1  start request to the transmitter
tx_busy  input  1  transmitter busy
tx_done  input  1  transmitter frame-complete pulse
grant_id  output  clog2(NUM_REQ)  index of the current or last granted source
active  output  1  a transfer is in progress (state != IDLE)
err_timeout  output  1  one-cycle pulse: tx_busy not seen within START_TO cycles

Behaviour:
- Reset (rst=0 at a clk edge) values: state=IDLE; tx_start=0, tx_data=0, req_ready=0, req_done=0, grant_id=0, active=0, err_timeout=0; last_grant=NUM_REQ-1, so source 0 has top priority first.
- Reset mid-transfer: abandon immediately. No req_done is issued, and the source's byte is lost.
- All outputs are registered.
- The state machine has three states: IDLE, START and WAIT_DONE.

IDLE:
- Grant condition: en=1 and any req_valid bit set.
- Winner: the first set bit scanning from (last_grant+1) mod NUM_REQ upward, wrapping around.
- On the granting edge:
  - tx_data <= the winner's byte; grant_id <= winner index; req_ready <= one-hot of the winner.
  - tx_start <= 1; active <= 1; timeout counter <= 0; state -> START.
- Latency: req_valid sampled high at edge n gives req_ready and tx_start high after edge n.

START:
- req_ready returns to 0 after exactly one cycle.
- tx_start is held at 1 until tx_busy=1 is sampled; this tolerates a transmitter that only samples on baud_tick.
- tx_busy=1: tx_start <= 0, state -> WAIT_DONE.
- tx_done=1 sampled in START (same edge as busy, or before it): treat as complete and run the WAIT_DONE completion actions.
- Counter reaches START_TO-1 with no busy:
  - tx_start <= 0; err_timeout pulses; active <= 0.
  - last_grant <= grant_id; state -> IDLE. No req_done is issued.

WAIT_DONE:
- On tx_done=1: req_done <= one-hot of grant_id for one cycle; last_grant <= grant_id; active <= 0; state -> IDLE.
- Back-to-back transfers have exactly one IDLE cycle between them.

Requester rules:
- req_data must be stable while req_valid=1 and the byte is not yet accepted.
- Valid is dropped or advanced on the cycle after req_ready.
- Dropping req_valid before a grant is legal and withdraws the request.
- Requests that arrive during a transfer wait; they are never lost.
- en=0 mid-transfer does not abort the transfer.
- tx_data keeps its last value in IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE/START/WAIT_DONE);
  - the DATA_W default (8);
  - a clog2 helper constant function for the grant_id and counter widths.
- One sub-module: uart_rr_pick, a combinational round-robin picker.
  - Inputs: req vector and last_grant. Outputs: winner index and a found flag.
  - Implemented as a rotated priority encoder.

Test Plan:
- Single source: req_valid=4'b0001, req_data[7:0]=8'h41 → next cycle req_ready=0001, tx_data=8'h41, tx_start=1 until tx_busy. After tx_done: req_done=0001 for one cycle, active=0.
- Simultaneous requests: valid=0011, bytes 8'h41 (src0) and 8'h42 (src1) → 0x41 is sent first, then 0x42. One idle cycle separates them, and req_done pulses 0001 then 0010.
- Fairness: all four sources held valid for 8 transfers → grant_id sequence 0,1,2,3,0,1,2,3. No source is granted twice before the others.
- en gating: en=0 with valid=0100 → no req_ready and tx_start stays 0. Raise en → src2 is granted. Dropping en during WAIT_DONE still yields req_done.
- Timeout: tx_busy tied 0, START_TO=16 → tx_start high for 16 cycles, then err_timeout pulses, no req_done, and the next source is granted.
- Reset mid-transfer: rst=0 during WAIT_DONE → next cycle all outputs are at reset values. After rst=1, src0 wins first even if src1 was the last grant.
